// File: rtl/inst_fetch_queue_if.sv
// Fetch-side and dequeue-side handshake bundle for inst_fetch_queue.
// master: the fetch queue itself. slave: memory/predictor/decoder side.
interface inst_fetch_queue_if #(
    parameter int XLEN = 32
);
    // memory_unit / predictor side
    logic            inst_req;
    logic [XLEN-1:0] fetch_pc;
    logic            inst_ready;
    logic [31:0]     inst;
    logic            pred_taken;
    // decoder / issue side
    logic            deq_valid;
    logic            deq_ready;
    logic [31:0]     deq_inst;
    logic [XLEN-1:0] deq_pc;
    logic            deq_pred;

    modport master (
        output inst_req, fetch_pc, deq_valid, deq_inst, deq_pc, deq_pred,
        input  inst_ready, inst, pred_taken, deq_ready
    );

    modport slave (
        input  inst_req, fetch_pc, deq_valid, deq_inst, deq_pc, deq_pred,
        output inst_ready, inst, pred_taken, deq_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Decoupled instruction fetch front end: one outstanding fetch at a time into
// a circular queue, with JAL/branch/JALR pre-decode steering the fetch PC.
module inst_fetch_queue #(
    parameter int              DEPTH_BIT = 3,
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic [XLEN-1:0]      clear_pc,
    input  logic                 stall_end,
    input  logic [XLEN-1:0]      jalr_addr,
    inst_fetch_queue_if.master   bus,
    output logic [DEPTH_BIT:0]   count,
    output logic                 full,
    output logic                 empty
);
    localparam int                 DEPTH     = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0] DEPTH_CNT = (DEPTH_BIT+1)'(DEPTH);
    localparam logic [6:0]         OP_JAL    = 7'b1101111;
    localparam logic [6:0]         OP_BR     = 7'b1100011;
    localparam logic [6:0]         OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STALL} state_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic            pred;
    } entry_t;

    state_t                 state_q, state_d;
    logic [XLEN-1:0]        fetch_pc_q, fetch_pc_d;
    logic                   inst_req_q, inst_req_d;
    logic [DEPTH_BIT-1:0]   head_q, head_d, tail_q, tail_d;
    logic [DEPTH_BIT:0]     count_q, count_d;
    entry_t                 mem_q [DEPTH];
    entry_t                 mem_d [DEPTH];

    logic                   do_enq, do_pop, enq_pred;
    logic [XLEN-1:0]        j_imm, b_imm;

    assign j_imm = {{(XLEN-21){bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                    bus.inst[20], bus.inst[30:21], 1'b0};
    assign b_imm = {{(XLEN-13){bus.inst[31]}}, bus.inst[31], bus.inst[7],
                    bus.inst[30:25], bus.inst[11:8], 1'b0};

    // Next-state: fetch FSM, pre-decode redirect, queue pointers and storage.
    // rdy_in low leaves every _d equal to its _q (including a pending inst_req).
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inst_req_d = inst_req_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        mem_d      = mem_q;
        do_enq     = 1'b0;
        do_pop     = 1'b0;
        enq_pred   = 1'b0;
        if (rdy_in) begin
            inst_req_d = 1'b0;
            if (clear) begin
                // Flush drops any same-cycle response and any pop.
                state_d    = S_IDLE;
                fetch_pc_d = clear_pc;
                head_d     = '0;
                tail_d     = '0;
                count_d    = '0;
            end else begin
                do_pop = !empty && bus.deq_ready;
                case (state_q)
                    S_IDLE: begin
                        if (count_q < DEPTH_CNT) begin
                            inst_req_d = 1'b1;
                            state_d    = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (bus.inst_ready) begin
                            do_enq  = 1'b1;
                            state_d = S_IDLE;
                            case (bus.inst[6:0])
                                OP_JAL: begin
                                    enq_pred   = 1'b1;
                                    fetch_pc_d = fetch_pc_q + j_imm;
                                end
                                OP_BR: begin
                                    enq_pred   = bus.pred_taken;
                                    fetch_pc_d = bus.pred_taken ? fetch_pc_q + b_imm
                                                                : fetch_pc_q + XLEN'(4);
                                end
                                // Target unknown until the backend resolves it.
                                OP_JALR: state_d = S_STALL;
                                default: fetch_pc_d = fetch_pc_q + XLEN'(4);
                            endcase
                        end
                    end
                    S_STALL: begin
                        if (stall_end) begin
                            fetch_pc_d = jalr_addr;
                            state_d    = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
                if (do_enq) begin
                    mem_d[tail_q] = '{inst: bus.inst, pc: fetch_pc_q, pred: enq_pred};
                    tail_d        = tail_q + 1'b1;
                end
                if (do_pop) head_d = head_q + 1'b1;
                case ({do_enq, do_pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            inst_req_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inst_req_q <= inst_req_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

    // Request is gated so a frozen pipeline never shows a pulse to memory.
    assign bus.inst_req  = inst_req_q && rdy_in;
    assign bus.fetch_pc  = fetch_pc_q;
    assign bus.deq_valid = !empty;
    assign bus.deq_inst  = mem_q[head_q].inst;
    assign bus.deq_pc    = mem_q[head_q].pc;
    assign bus.deq_pred  = mem_q[head_q].pred;
    assign count         = count_q;
    assign full          = (count_q == DEPTH_CNT);
    assign empty         = (count_q == '0);

    a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_n_in)
                                    !(do_enq && full));
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a one-cycle-latency memory model.
`timescale 1ns/1ps
module tb_inst_fetch_queue;
    localparam int          DB   = 2;
    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JAL  = 32'hFF9F_F06F;
    localparam logic [31:0] BEQ  = 32'h0000_0863;
    localparam logic [31:0] JALR = 32'h0000_8067;

    logic             clk_in = 1'b0;
    logic             rst_n_in, rdy_in, clear, stall_end;
    logic [XLEN-1:0]  clear_pc, jalr_addr;
    logic [DB:0]      count;
    logic             full, empty;
    int               checks = 0;
    int               failures = 0;

    inst_fetch_queue_if #(.XLEN(XLEN)) ifc();

    inst_fetch_queue #(.DEPTH_BIT(DB), .XLEN(XLEN), .RESET_PC(32'h0)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .clear(clear),
        .clear_pc(clear_pc), .stall_end(stall_end), .jalr_addr(jalr_addr),
        .bus(ifc), .count(count), .full(full), .empty(empty)
    );

    always #5 clk_in = ~clk_in;

    // Memory model: answers one cycle after a request, holds while rdy_in low,
    // aborts on clear; mem_en=0 withholds the answer.
    logic [31:0] prog [logic [31:0]];
    logic        mem_en, pend;
    logic [31:0] pend_inst;
    always @(posedge clk_in) begin
        if (!rst_n_in) pend <= 1'b0;
        else if (rdy_in) begin
            if (clear || (pend && mem_en)) pend <= 1'b0;
            if (ifc.inst_req && !clear) begin
                pend      <= 1'b1;
                pend_inst <= prog.exists(ifc.fetch_pc) ? prog[ifc.fetch_pc] : NOP;
            end
        end
    end
    assign ifc.inst_ready = pend && mem_en;
    assign ifc.inst       = pend_inst;

    logic [31:0] pop_pc   [8];
    logic        pop_pred [8];
    logic [31:0] pop_inst [8];
    int          max_cnt;
    logic        saw_req;
    logic [31:0] first_req_pc;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; clear_pc = '0;
        stall_end = 1'b0; jalr_addr = '0; mem_en = 1'b1;
        ifc.deq_ready = 1'b0; ifc.pred_taken = 1'b0;
        prog.delete();
        tick(); tick();
        rst_n_in = 1'b1;
    endtask

    // Records popped entries (pop lands on the following edge) plus the first request.
    task automatic collect_pops(input int n, output bit timed_out);
        int got = 0;
        max_cnt = 0; saw_req = 1'b0; first_req_pc = '0;
        for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (ifc.inst_req && !saw_req) begin saw_req = 1'b1; first_req_pc = ifc.fetch_pc; end
            if (ifc.deq_valid && ifc.deq_ready && rdy_in) begin
                pop_pc[got] = ifc.deq_pc; pop_pred[got] = ifc.deq_pred; pop_inst[got] = ifc.deq_inst;
                got++;
            end
            tick();
        end
        timed_out = (got < n);
    endtask

    task automatic test_reset();
        do_reset();
        rst_n_in = 1'b0; clear = 1'b1; clear_pc = 32'h55;
        tick(); tick();
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (ifc.deq_valid !== 1'b0) begin failures++; $display("FAIL reset_deq_valid got=%b exp=0", ifc.deq_valid); end
        checks++; if (ifc.fetch_pc !== 32'h0) begin failures++; $display("FAIL reset_fetch_pc got=%h exp=0", ifc.fetch_pc); end
        checks++; if (ifc.inst_req !== 1'b0) begin failures++; $display("FAIL reset_inst_req got=%b exp=0", ifc.inst_req); end
        clear = 1'b0; rst_n_in = 1'b1;
        tick();
        checks++; if (ifc.inst_req !== 1'b1 || ifc.fetch_pc !== 32'h0) begin
            failures++; $display("FAIL reset_first_req got=%b/%h exp=1/0", ifc.inst_req, ifc.fetch_pc); end
    endtask

    task automatic test_sequential();
        bit to;
        do_reset();
        ifc.deq_ready = 1'b1;
        collect_pops(4, to);
        checks++; if (to) begin failures++; $display("FAIL seq_timeout got=timeout exp=4 pops"); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (pop_pc[i] !== 32'(i*4)) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pop_pc[i], i*4); end
        end
        checks++; if (max_cnt > 1) begin failures++; $display("FAIL seq_max_count got=%0d exp<=1", max_cnt); end
    endtask

    task automatic test_full();
        bit to;
        bit any_req = 1'b0;
        do_reset();
        for (int c = 0; c < 60 && count !== 3'd4; c++) tick();
        for (int c = 0; c < 5; c++) begin if (ifc.inst_req) any_req = 1'b1; tick(); end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full); end
        checks++; if (any_req !== 1'b0) begin failures++; $display("FAIL full_req_silent got=%b exp=0", any_req); end
        checks++; if (ifc.fetch_pc !== 32'h10) begin failures++; $display("FAIL full_fetch_pc got=%h exp=10", ifc.fetch_pc); end
        ifc.deq_ready = 1'b1;
        collect_pops(5, to);
        checks++; if (to) begin failures++; $display("FAIL full_drain_timeout got=timeout exp=5 pops"); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (pop_pc[i] !== 32'(i*4)) begin failures++; $display("FAIL full_pop_pc[%0d] got=%h exp=%h", i, pop_pc[i], i*4); end
        end
        checks++; if (!saw_req || first_req_pc !== 32'h10) begin
            failures++; $display("FAIL full_resume_pc got=%b/%h exp=1/10", saw_req, first_req_pc); end
    endtask

    task automatic test_jal();
        bit to;
        do_reset();
        prog[32'h8] = JAL;
        ifc.deq_ready = 1'b1;
        collect_pops(5, to);
        checks++; if (to) begin failures++; $display("FAIL jal_timeout got=timeout exp=5 pops"); end
        checks++; if (pop_pc[2] !== 32'h8 || pop_pred[2] !== 1'b1 || pop_inst[2] !== JAL) begin
            failures++; $display("FAIL jal_entry got=%h/%b/%h exp=8/1/%h", pop_pc[2], pop_pred[2], pop_inst[2], JAL); end
        checks++; if (pop_pred[1] !== 1'b0) begin failures++; $display("FAIL jal_prev_pred got=%b exp=0", pop_pred[1]); end
        checks++; if (pop_pc[3] !== 32'h0 || pop_pc[4] !== 32'h4) begin
            failures++; $display("FAIL jal_target got=%h,%h exp=0,4", pop_pc[3], pop_pc[4]); end
    endtask

    task automatic test_branch();
        bit to;
        for (int t = 1; t >= 0; t--) begin
            do_reset();
            prog[32'h10] = BEQ;
            ifc.pred_taken = t[0];
            ifc.deq_ready = 1'b1;
            collect_pops(6, to);
            checks++; if (to) begin failures++; $display("FAIL br%0d_timeout got=timeout exp=6 pops", t); end
            checks++; if (pop_pc[3] !== 32'hc || pop_pred[3] !== 1'b0) begin
                failures++; $display("FAIL br%0d_nonbranch got=%h/%b exp=c/0", t, pop_pc[3], pop_pred[3]); end
            checks++; if (pop_pc[4] !== 32'h10 || pop_pred[4] !== t[0]) begin
                failures++; $display("FAIL br%0d_entry got=%h/%b exp=10/%0d", t, pop_pc[4], pop_pred[4], t); end
            checks++; if (pop_pc[5] !== (t != 0 ? 32'h20 : 32'h14)) begin
                failures++; $display("FAIL br%0d_next got=%h exp=%h", t, pop_pc[5], (t != 0 ? 32'h20 : 32'h14)); end
        end
    endtask

    task automatic test_jalr();
        bit found = 1'b0;
        bit any_req = 1'b0;
        bit seen = 1'b0;
        do_reset();
        prog[32'h24] = JALR;
        ifc.deq_ready = 1'b1;
        for (int c = 0; c < 100 && !found; c++) begin
            if (ifc.inst_ready && ifc.fetch_pc == 32'h24) found = 1'b1;
            else tick();
        end
        checks++; if (!found) begin failures++; $display("FAIL jalr_reach got=timeout exp=resp at 24"); end
        tick();
        for (int c = 0; c < 5; c++) begin if (ifc.inst_req) any_req = 1'b1; tick(); end
        checks++; if (any_req !== 1'b0) begin failures++; $display("FAIL jalr_stall_req got=%b exp=0", any_req); end
        stall_end = 1'b1; jalr_addr = 32'h100;
        tick();
        stall_end = 1'b0;
        checks++; if (ifc.fetch_pc !== 32'h100) begin failures++; $display("FAIL jalr_fetch_pc got=%h exp=100", ifc.fetch_pc); end
        for (int c = 0; c < 5 && !seen; c++) begin
            if (ifc.inst_req) seen = 1'b1; else tick();
        end
        checks++; if (!seen || ifc.fetch_pc !== 32'h100) begin
            failures++; $display("FAIL jalr_resume got=%b/%h exp=1/100", seen, ifc.fetch_pc); end
    endtask

    task automatic test_clear();
        bit to;
        do_reset();
        for (int c = 0; c < 60 && count !== 3'd3; c++) tick();
        mem_en = 1'b0;
        repeat (4) tick();
        checks++; if (count !== 3'd3 || ifc.fetch_pc !== 32'hc) begin
            failures++; $display("FAIL clr_pre got=%0d/%h exp=3/c", count, ifc.fetch_pc); end
        clear = 1'b1; clear_pc = 32'h200; mem_en = 1'b1; ifc.deq_ready = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (count !== 3'd0 || empty !== 1'b1 || ifc.deq_valid !== 1'b0) begin
            failures++; $display("FAIL clr_flush got=%0d/%b/%b exp=0/1/0", count, empty, ifc.deq_valid); end
        checks++; if (ifc.fetch_pc !== 32'h200) begin failures++; $display("FAIL clr_fetch_pc got=%h exp=200", ifc.fetch_pc); end
        collect_pops(1, to);
        checks++; if (to || !saw_req || first_req_pc !== 32'h200) begin
            failures++; $display("FAIL clr_next_req got=%b/%b/%h exp=0/1/200", to, saw_req, first_req_pc); end
        checks++; if (pop_pc[0] !== 32'h200) begin failures++; $display("FAIL clr_first_pop got=%h exp=200", pop_pc[0]); end
    endtask

    task automatic test_rdy_freeze();
        bit to;
        do_reset();
        for (int c = 0; c < 60 && count !== 3'd2; c++) tick();
        for (int c = 0; c < 10 && !ifc.inst_ready; c++) tick();
        rdy_in = 1'b0; ifc.deq_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (count !== 3'd2 || ifc.deq_pc !== 32'h0 || ifc.inst_req !== 1'b0) begin
                failures++; $display("FAIL frz_hold[%0d] got=%0d/%h/%b exp=2/0/0", c, count, ifc.deq_pc, ifc.inst_req); end
        end
        rdy_in = 1'b1; ifc.deq_ready = 1'b0;
        tick();
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL frz_enq got=%0d exp=3", count); end
        tick(); tick();
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL frz_once got=%0d exp=3", count); end
        ifc.deq_ready = 1'b1;
        collect_pops(4, to);
        checks++; if (to) begin failures++; $display("FAIL frz_timeout got=timeout exp=4 pops"); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (pop_pc[i] !== 32'(i*4)) begin failures++; $display("FAIL frz_pop_pc[%0d] got=%h exp=%h", i, pop_pc[i], i*4); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_full();
        test_jal();
        test_branch();
        test_jalr();
        test_clear();
        test_rdy_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
